instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 165 ++++++++++++++++
 tb/tb_instr_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Serial instruction loader: synchronizes a push-button strobe and data bit,
// shifts 16 bits MSB-first, then commits opcode/instr and waits for the core.
module instr_loader #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        btn_raw,
    input  logic        ser_in,
    input  logic        abort,
    input  logic        core_busy,
    output logic        btn_edge,
    output logic [3:0]  opcode,
    output logic [11:0] instr,
    output logic        inst_done,
    output logic        loading,
    output logic [4:0]  bit_cnt
);

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned FILL_W   = 3;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORD_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        EXEC  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic [SYNC_STAGES-1:0] ser_sync_q;
    logic                   btn_s;
    logic                   ser_s;
    logic                   prev_q;
    logic [FILL_W-1:0]      fill_q;
    logic                   edge_ok;
    logic                   btn_edge_q;
    logic                   ser_bit_q;

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [11:0]       instr_q, instr_d;
    logic              done_q, done_d;
    logic              loading_q, loading_d;

    assign btn_s   = btn_sync_q[SYNC_STAGES-1];
    assign ser_s   = ser_sync_q[SYNC_STAGES-1];
    // Edges are suppressed until the chains have flushed after reset, so a
    // button already held at release does not look like a fresh press.
    assign edge_ok = (fill_q == FILL_MAX);

    // Equal-depth synchronizers keep the data bit coherent with its strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            btn_sync_q <= '0;
            ser_sync_q <= '0;
            prev_q     <= 1'b0;
            fill_q     <= '0;
            btn_edge_q <= 1'b0;
            ser_bit_q  <= 1'b0;
        end else begin
            btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], btn_raw};
            ser_sync_q <= {ser_sync_q[SYNC_STAGES-2:0], ser_in};
            prev_q     <= btn_s;
            if (!edge_ok) begin
                fill_q <= fill_q + FILL_W'(1);
            end
            btn_edge_q <= btn_s & ~prev_q & edge_ok;
            ser_bit_q  <= ser_s;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (btn_edge_q) state_d = SHIFT;
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_FULL) begin
                    state_d = DONE;
                end
            end
            DONE:  state_d = EXEC;
            EXEC:  if (!core_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; commit lands in the DONE cycle
    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        opcode_d  = opcode_q;
        instr_d   = instr_q;
        done_d    = 1'b0;
        loading_d = (state_d == SHIFT);
        case (state_q)
            IDLE: begin
                if (btn_edge_q) begin
                    shift_d = {shift_q[WORD_W-2:0], ser_bit_q};
                    cnt_d   = CNT_W'(1);
                end
            end
            SHIFT: begin
                if (abort) begin
                    shift_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_FULL) begin
                    opcode_d = shift_q[15:12];
                    instr_d  = shift_q[11:0];
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    shift_d  = '0;
                end else if (btn_edge_q) begin
                    shift_d = {shift_q[WORD_W-2:0], ser_bit_q};
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            opcode_q  <= '0;
            instr_q   <= '0;
            done_q    <= 1'b0;
            loading_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            opcode_q  <= opcode_d;
            instr_q   <= instr_d;
            done_q    <= done_d;
            loading_q <= loading_d;
        end
    end

    assign btn_edge  = btn_edge_q;
    assign opcode    = opcode_q;
    assign instr     = instr_q;
    assign inst_done = done_q;
    assign loading   = loading_q;
    assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: vector table of full loads plus hand
// sequences for abort, busy core, reset and strobe timing corners.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        btn_raw;
    logic        ser_in;
    logic        abort;
    logic        core_busy;
    logic        btn_edge;
    logic [3:0]  opcode;
    logic [11:0] instr;
    logic        inst_done;
    logic        loading;
    logic [4:0]  bit_cnt;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [15:0] word;
        logic [3:0]  op;
        logic [11:0] ins;
    } vec_t;

    vec_t vecs[5];

    instr_loader #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .btn_raw   (btn_raw),
        .ser_in    (ser_in),
        .abort     (abort),
        .core_busy (core_busy),
        .btn_edge  (btn_edge),
        .opcode    (opcode),
        .instr     (instr),
        .inst_done (inst_done),
        .loading   (loading),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (inst_done) done_cnt++;
        if (btn_edge)  edge_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic press(input logic b);
        ser_in  = b;
        btn_raw = 1'b1;
        repeat (4) step();
        btn_raw = 1'b0;
        repeat (4) step();
    endtask

    task automatic load_bits(input logic [15:0] w, input int n);
        for (int i = 15; i > 15 - n; i--) press(w[i]);
    endtask

    int d0, e0;

    initial begin
        vecs[0] = '{16'h1234, 4'h1, 12'h234};
        vecs[1] = '{16'hFFFF, 4'hF, 12'hFFF};
        vecs[2] = '{16'h0000, 4'h0, 12'h000};
        vecs[3] = '{16'h8001, 4'h8, 12'h001};
        vecs[4] = '{16'h7E5B, 4'h7, 12'hE5B};

        rstn = 1'b0; btn_raw = 1'b0; ser_in = 1'b0; abort = 1'b0; core_busy = 1'b0;
        repeat (3) step();
        chk("rst_btn_edge", 32'(btn_edge), 32'd0);
        chk("rst_opcode",   32'(opcode),   32'd0);
        chk("rst_instr",    32'(instr),    32'd0);
        chk("rst_done",     32'(inst_done), 32'd0);
        chk("rst_loading",  32'(loading),  32'd0);
        chk("rst_bit_cnt",  32'(bit_cnt),  32'd0);
        rstn = 1'b1;
        repeat (6) step();

        // held button: one pulse on the 3rd clock edge after the rise
        e0 = edge_cnt;
        ser_in = 1'b0; btn_raw = 1'b1;
        step(); chk("edge_c1", 32'(btn_edge), 32'd0);
        step(); chk("edge_c2", 32'(btn_edge), 32'd0);
        step(); chk("edge_c3", 32'(btn_edge), 32'd1);
        step(); chk("edge_c4", 32'(btn_edge), 32'd0);
        repeat (46) step();
        chk("held_one_pulse", 32'(edge_cnt - e0), 32'd1);
        chk("held_cnt", 32'(bit_cnt), 32'd1);
        chk("held_loading", 32'(loading), 32'd1);
        btn_raw = 1'b0;
        repeat (4) step();
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort1_cnt", 32'(bit_cnt), 32'd0);
        chk("abort1_loading", 32'(loading), 32'd0);
        repeat (2) step();

        // A5C3 with cycle-exact commit
        d0 = done_cnt;
        load_bits(16'hA5C3, 15);
        chk("a5_cnt15", 32'(bit_cnt), 32'd15);
        ser_in = 1'b1; btn_raw = 1'b1;
        repeat (3) step();
        step();
        chk("a5_cnt16", 32'(bit_cnt), 32'd16);
        chk("a5_load16", 32'(loading), 32'd1);
        chk("a5_nodone_yet", 32'(inst_done), 32'd0);
        btn_raw = 1'b0;
        step();
        chk("a5_done", 32'(inst_done), 32'd1);
        chk("a5_opcode", 32'(opcode), 32'hA);
        chk("a5_instr", 32'(instr), 32'h5C3);
        chk("a5_cnt0", 32'(bit_cnt), 32'd0);
        chk("a5_load0", 32'(loading), 32'd0);
        step();
        chk("a5_done_low", 32'(inst_done), 32'd0);
        repeat (4) step();
        chk("a5_single_done", 32'(done_cnt - d0), 32'd1);

        for (int v = 0; v < 5; v++) begin
            d0 = done_cnt;
            load_bits(vecs[v].word, 16);
            repeat (2) step();
            chk($sformatf("vec%0d_opcode", v), 32'(opcode), 32'(vecs[v].op));
            chk($sformatf("vec%0d_instr", v), 32'(instr), 32'(vecs[v].ins));
            chk($sformatf("vec%0d_done", v), 32'(done_cnt - d0), 32'd1);
            chk($sformatf("vec%0d_cnt", v), 32'(bit_cnt), 32'd0);
        end

        // partial load then abort leaves committed word alone
        load_bits(16'hA5FF, 8);
        chk("ab_cnt8", 32'(bit_cnt), 32'd8);
        abort = 1'b1; step(); abort = 1'b0;
        chk("ab_cnt0", 32'(bit_cnt), 32'd0);
        chk("ab_loading", 32'(loading), 32'd0);
        chk("ab_opcode_hold", 32'(opcode), 32'h7);
        chk("ab_instr_hold", 32'(instr), 32'hE5B);
        repeat (2) step();
        load_bits(16'h1234, 16);
        repeat (2) step();
        chk("ab_reload_op", 32'(opcode), 32'h1);
        chk("ab_reload_in", 32'(instr), 32'h234);

        // busy core: presses during EXEC are ignored, incl. the exit cycle
        core_busy = 1'b1;
        d0 = done_cnt;
        load_bits(16'h0F0F, 16);
        chk("busy_done", 32'(done_cnt - d0), 32'd1);
        chk("busy_instr", 32'(instr), 32'hF0F);
        e0 = edge_cnt;
        for (int p = 0; p < 4; p++) press(1'b1);
        chk("busy_cnt", 32'(bit_cnt), 32'd0);
        chk("busy_loading", 32'(loading), 32'd0);
        ser_in = 1'b1; btn_raw = 1'b1;
        repeat (3) step();
        core_busy = 1'b0;
        step();
        btn_raw = 1'b0;
        repeat (4) step();
        chk("exit_edge_cnt", 32'(bit_cnt), 32'd0);
        chk("exit_loading", 32'(loading), 32'd0);
        chk("busy_edges", 32'(edge_cnt - e0), 32'd5);
        chk("busy_no_extra_done", 32'(done_cnt - d0), 32'd1);
        load_bits(16'h3C5A, 16);
        repeat (2) step();
        chk("post_busy_op", 32'(opcode), 32'h3);
        chk("post_busy_in", 32'(instr), 32'hC5A);

        // abort coincident with the 16th edge
        d0 = done_cnt;
        load_bits(16'h5555, 15);
        ser_in = 1'b1; btn_raw = 1'b1;
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab16_cnt", 32'(bit_cnt), 32'd0);
        chk("ab16_loading", 32'(loading), 32'd0);
        btn_raw = 1'b0;
        repeat (6) step();
        chk("ab16_no_done", 32'(done_cnt - d0), 32'd0);
        chk("ab16_op_hold", 32'(opcode), 32'h3);

        // reset mid-load
        load_bits(16'h2AAA, 10);
        chk("mid_cnt10", 32'(bit_cnt), 32'd10);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_cnt", 32'(bit_cnt), 32'd0);
        chk("mid_rst_load", 32'(loading), 32'd0);
        chk("mid_rst_op", 32'(opcode), 32'd0);
        chk("mid_rst_in", 32'(instr), 32'd0);
        chk("mid_rst_edge", 32'(btn_edge), 32'd0);
        step();
        rstn = 1'b1;
        repeat (6) step();
        load_bits(16'hFFFF, 16);
        repeat (2) step();
        chk("mid_ff_op", 32'(opcode), 32'hF);
        chk("mid_ff_in", 32'(instr), 32'hFFF);

        // reset release with button already held
        btn_raw = 1'b1;
        step();
        rstn = 1'b0;
        step();
        e0 = edge_cnt;
        rstn = 1'b1;
        repeat (10) step();
        chk("rel_no_edge", 32'(edge_cnt - e0), 32'd0);
        chk("rel_cnt", 32'(bit_cnt), 32'd0);
        chk("rel_loading", 32'(loading), 32'd0);
        btn_raw = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
